instr_decode_pipe: RTL and testbench
====================================

Name: instr_decode_pipe

Overview:
Parametrised, registered successor to the combinational instruction-field decoder. It accepts raw instruction words from the instruction buffer over a valid/ready handshake and splits each word into systolic-array and VPU SIMD fields. It presents the decoded bundle to the control FSM through a 2-entry skid stage, so the decoder never stalls on a registered ready. It adds a per-instruction sequence tag, HALT-word detection with a RUN/HALTED state machine, and an optional illegal-field check.

Parameters:
ADDR_W, 13, width of each address field (a, b, out, const)
OPC_W, 10, opcode field width
MODE_W, 2, mode field width (top bits of the word)
SEQ_W, 8, sequence tag width
VPU_TYPE_MAX, 5, first illegal vpu_type value (used only with the optional feature)
Derived localparams:
- INSTR_W = MODE_W + 4*ADDR_W + OPC_W (default 64)
- LEN_W = ADDR_W + OPC_W (default 23)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction word valid
in_ready  out  1  decoder can accept a word
in_instr  in  INSTR_W  raw instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  consumer accepts bundle
out_mode  out  MODE_W  bits [INSTR_W-1 -: MODE_W]
out_addr_a  out  ADDR_W  next field below mode
out_addr_b  out  ADDR_W  next field below addr_a
out_addr_out  out  ADDR_W  next field below addr_b
out_addr_const  out  ADDR_W  bits [LEN_W-1:OPC_W]
out_opcode  out  OPC_W  bits [OPC_W-1:0]
out_len  out  LEN_W  bits [LEN_W-1:0]
out_vpu_type  out  3  bits [LEN_W-1 -: 3]
out_vreg_dst  out  3  next 3 bits below vpu_type
out_vreg_a  out  3  next 3 bits below vreg_dst
out_vreg_b  out  3  next 3 bits below vreg_a
out_vpu_opcode  out  3  bits [6:4]
out_scalar_b  out  1  bit [3]
out_seq  out  SEQ_W  sequence tag of the bundle
out_illegal  out  1  bundle has an illegal field (optional feature)
halted  out  1  HALT word seen; input blocked
halt_clr  in  1  single-cycle pulse: return to RUN and zero the sequence counter

Behaviour:
- Reset values (rst_n low at a clk edge):
  - out_valid=0, halted=0, out_seq=0, out_illegal=0; all other data outputs 0.
  - Skid entry invalid; state RUN; sequence counter 0.
  - Reset mid-transfer discards both buffered entries.
- States:
  - RUN: accepts input.
  - HALTED: in_ready=0; out stage still drains.
- Transitions:
  - RUN->HALTED when an accepted word is all-ones (HALT). The HALT word is consumed and not forwarded.
  - HALTED->RUN on halt_clr; the sequence counter is zeroed on the same edge.
  - halt_clr in RUN zeroes the counter only.
  - halt_clr together with in_valid while HALTED: the word is not accepted that cycle.
- Handshake:
  - in_ready = (state==RUN) && !skid_valid. It is a pure register output, with no combinational path from out_ready.
  - Accept when in_valid && in_ready. Latency is 1 cycle: a word accepted at edge N is visible on out_* after edge N.
- Skid stage:
  - If the out register is full and not being popped on an accept, the decoded word goes to the skid entry.
  - On an out pop, the skid entry moves to the out register.
  - Order is strictly preserved.
  - out_* hold stable while out_valid && !out_ready.
- Sequence tag:
  - Captured from the counter on accept; the counter then increments, wrapping modulo 2^SEQ_W (255 -> 0).
  - HALT words do not increment the counter.
- Decode is purely bit-slicing; no arithmetic. VPU fields overlap the len/addr_const bits intentionally.

Optional Feature:
- Macro: INSTR_DECODE_ILLEGAL_CHECK_EN.
- Defined:
  - out_illegal=1 when vpu_type >= VPU_TYPE_MAX and mode==2'b11 (VPU mode).
  - The bundle is still forwarded; the flag travels with its bundle through the skid entry.
- Undefined: out_illegal is tied to 0 and no check logic is built.

Decomposition:
- Package instr_decode_pkg:
  - decoded_instr_t packed struct of all out_* fields plus seq and illegal.
  - HALT_WORD constant.
  - Field-offset localparams as functions of ADDR_W/OPC_W/MODE_W.
  - VPU field offsets.
- One sub-module, decode_skid_buf: 2-entry valid/ready skid buffer over decoded_instr_t.
- The field slicer stays inline.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> out_valid=0, in_ready=1 after release, halted=0, out_seq=0.
- in_instr=64'h4000_0000_0000_0003, out_ready=1 -> one cycle later out_mode=2'b01, out_opcode=10'h003, out_addr_*=0, out_seq=0.
- Backpressure: out_ready=0, push 2 words -> in_ready drops after the 2nd; raise out_ready -> both emerge in order with seq 0,1 and no loss or duplication.
- Push 256 ordinary words -> the 257th carries out_seq=0 (wrap).
- Push word A, then 64'hFFFF_FFFF_FFFF_FFFF, then word B held valid:
  - A is forwarded; halted=1; B is not accepted.
  - Pulse halt_clr -> B accepted with out_seq=0.
- With INSTR_DECODE_ILLEGAL_CHECK_EN, mode=3, vpu_type=3'd6 -> out_illegal=1. With vpu_type=3'd2 -> 0. Without the macro -> always 0.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Purpose : shared field layout, decoded-bundle struct and FSM encoding for instr_decode_pipe.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Field map of the default 64-bit word (msb..lsb):
//   mode[63:62] addr_a[61:49] addr_b[48:36] addr_out[35:23] addr_const[22:10] opcode[9:0]
//   len = addr_const:opcode; VPU view of len: vpu_type[22:20] vreg_dst[19:17] vreg_a[16:14]
//   vreg_b[13:11] vpu_opcode[6:4] scalar_b[3]
package instr_decode_pkg;

  localparam int DEC_ADDR_W  = 13;
  localparam int DEC_OPC_W   = 10;
  localparam int DEC_MODE_W  = 2;
  localparam int DEC_SEQ_W   = 8;
  localparam int DEC_INSTR_W = DEC_MODE_W + 4*DEC_ADDR_W + DEC_OPC_W;
  localparam int DEC_LEN_W   = DEC_ADDR_W + DEC_OPC_W;

  // Systolic-array field offsets, walking down from the mode bits.
  localparam int MODE_LSB       = DEC_INSTR_W - DEC_MODE_W;
  localparam int ADDR_A_LSB     = MODE_LSB - DEC_ADDR_W;
  localparam int ADDR_B_LSB     = ADDR_A_LSB - DEC_ADDR_W;
  localparam int ADDR_OUT_LSB   = ADDR_B_LSB - DEC_ADDR_W;
  localparam int ADDR_CONST_LSB = DEC_OPC_W;

  // VPU SIMD view; these deliberately alias the len/addr_const bits.
  localparam int VPU_TYPE_LSB = DEC_LEN_W - 3;
  localparam int VREG_DST_LSB = VPU_TYPE_LSB - 3;
  localparam int VREG_A_LSB   = VREG_DST_LSB - 3;
  localparam int VREG_B_LSB   = VREG_A_LSB - 3;
  localparam int VPU_OPC_LSB  = 4;
  localparam int SCALAR_B_BIT = 3;

  localparam logic [DEC_MODE_W-1:0]  VPU_MODE  = 2'b11;
  localparam logic [DEC_INSTR_W-1:0] HALT_WORD = '1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEC_MODE_W-1:0] mode;
    logic [DEC_ADDR_W-1:0] addr_a;
    logic [DEC_ADDR_W-1:0] addr_b;
    logic [DEC_ADDR_W-1:0] addr_out;
    logic [DEC_ADDR_W-1:0] addr_const;
    logic [DEC_OPC_W-1:0]  opcode;
    logic [DEC_LEN_W-1:0]  len;
    logic [2:0]            vpu_type;
    logic [2:0]            vreg_dst;
    logic [2:0]            vreg_a;
    logic [2:0]            vreg_b;
    logic [2:0]            vpu_opcode;
    logic                  scalar_b;
    logic [DEC_SEQ_W-1:0]  seq;
    logic                  illegal;
  } decoded_instr_t;

endpackage

// File: rtl/decode_skid_buf.sv
// Purpose : 2-entry valid/ready skid buffer (out register + one skid entry) over decoded_instr_t.
// Latency : 1 cycle from in_vld accept to out_vld.
// Backpr. : in_rdy = !skid_vld_q, a pure register term; never depends on out_rdy.
// Ports   : clk, rst_n (sync, active-low); in_vld/in_rdy/in_dat upstream; out_vld/out_rdy/out_dat downstream.
module decode_skid_buf
  import instr_decode_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  output logic           in_rdy,
  input  decoded_instr_t in_dat,
  output logic           out_vld,
  input  logic           out_rdy,
  output decoded_instr_t out_dat
);

  logic           out_vld_q, out_vld_d;
  logic           skid_vld_q, skid_vld_d;
  decoded_instr_t out_dat_q, out_dat_d;
  decoded_instr_t skid_dat_q, skid_dat_d;

  logic push;
  logic pop;

  assign in_rdy  = !skid_vld_q;
  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;

  assign push = in_vld && !skid_vld_q;
  assign pop  = out_vld_q && out_rdy;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;

    // Drain first so a simultaneous push sees the post-pop occupancy.
    if (pop) begin
      if (skid_vld_q) begin
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end

    if (push) begin
      if (!out_vld_d) begin
        out_vld_d = 1'b1;
        out_dat_d = in_dat;
      end else begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_dat_q  <= '0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_dat_q  <= out_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// Purpose : registered instruction-field decoder with sequence tags and HALT detection (RUN/HALTED).
// Latency : 1 cycle from accept to out_valid.
// Backpr. : 2-entry skid stage; in_ready is register-only (RUN && skid entry empty).
// Ports   : clk, rst_n (sync, active-low); in_valid/in_ready/in_instr; out_valid/out_ready/out_* bundle;
//           halted status; halt_clr pulse (resume and zero the sequence counter).
// Option  : INSTR_DECODE_ILLEGAL_CHECK_EN builds the VPU illegal-type check and the VPU_TYPE_MAX parameter.
// Struct widths come from instr_decode_pkg, so the width parameters must keep their default values.
module instr_decode_pipe
  import instr_decode_pkg::*;
#(
  parameter  int ADDR_W       = DEC_ADDR_W,
  parameter  int OPC_W        = DEC_OPC_W,
  parameter  int MODE_W       = DEC_MODE_W,
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
  parameter  int VPU_TYPE_MAX = 5,
`endif
  parameter  int SEQ_W        = DEC_SEQ_W,
  localparam int INSTR_W      = MODE_W + 4*ADDR_W + OPC_W,
  localparam int LEN_W        = ADDR_W + OPC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MODE_W-1:0]  out_mode,
  output logic [ADDR_W-1:0]  out_addr_a,
  output logic [ADDR_W-1:0]  out_addr_b,
  output logic [ADDR_W-1:0]  out_addr_out,
  output logic [ADDR_W-1:0]  out_addr_const,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [LEN_W-1:0]   out_len,
  output logic [2:0]         out_vpu_type,
  output logic [2:0]         out_vreg_dst,
  output logic [2:0]         out_vreg_a,
  output logic [2:0]         out_vreg_b,
  output logic [2:0]         out_vpu_opcode,
  output logic               out_scalar_b,
  output logic [SEQ_W-1:0]   out_seq,
  output logic               out_illegal,
  output logic               halted,
  input  logic               halt_clr
);

  state_t               state_q, state_d;
  logic [DEC_SEQ_W-1:0] seq_q, seq_d;

  logic           skid_in_rdy;
  logic           accept;
  logic           is_halt;
  decoded_instr_t dec;
  decoded_instr_t out_dat;

  assign in_ready = (state_q == ST_RUN) && skid_in_rdy;
  assign accept   = in_valid && in_ready;
  assign is_halt  = (in_instr == HALT_WORD);
  assign halted   = (state_q == ST_HALTED);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    case (state_q)
      ST_RUN:    if (accept && is_halt) state_d = ST_HALTED;
      ST_HALTED: if (halt_clr)          state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    if (accept && !is_halt) seq_d = seq_q + DEC_SEQ_W'(1);
    // Clear beats increment so the next accepted word after a clear is tagged 0.
    if (halt_clr) seq_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  // Field slicer: pure bit selection; VPU fields overlap len on purpose.
  always_comb begin
    dec            = '0;
    dec.mode       = in_instr[MODE_LSB +: DEC_MODE_W];
    dec.addr_a     = in_instr[ADDR_A_LSB +: DEC_ADDR_W];
    dec.addr_b     = in_instr[ADDR_B_LSB +: DEC_ADDR_W];
    dec.addr_out   = in_instr[ADDR_OUT_LSB +: DEC_ADDR_W];
    dec.addr_const = in_instr[ADDR_CONST_LSB +: DEC_ADDR_W];
    dec.opcode     = in_instr[0 +: DEC_OPC_W];
    dec.len        = in_instr[0 +: DEC_LEN_W];
    dec.vpu_type   = in_instr[VPU_TYPE_LSB +: 3];
    dec.vreg_dst   = in_instr[VREG_DST_LSB +: 3];
    dec.vreg_a     = in_instr[VREG_A_LSB +: 3];
    dec.vreg_b     = in_instr[VREG_B_LSB +: 3];
    dec.vpu_opcode = in_instr[VPU_OPC_LSB +: 3];
    dec.scalar_b   = in_instr[SCALAR_B_BIT];
    dec.seq        = seq_q;
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
    dec.illegal    = (dec.mode == VPU_MODE) && (int'(dec.vpu_type) >= VPU_TYPE_MAX);
`endif
  end

  // HALT words are consumed here and never enter the output stage.
  decode_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (accept && !is_halt),
    .in_rdy  (skid_in_rdy),
    .in_dat  (dec),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (out_dat)
  );

  assign out_mode       = out_dat.mode;
  assign out_addr_a     = out_dat.addr_a;
  assign out_addr_b     = out_dat.addr_b;
  assign out_addr_out   = out_dat.addr_out;
  assign out_addr_const = out_dat.addr_const;
  assign out_opcode     = out_dat.opcode;
  assign out_len        = out_dat.len;
  assign out_vpu_type   = out_dat.vpu_type;
  assign out_vreg_dst   = out_dat.vreg_dst;
  assign out_vreg_a     = out_dat.vreg_a;
  assign out_vreg_b     = out_dat.vreg_b;
  assign out_vpu_opcode = out_dat.vpu_opcode;
  assign out_scalar_b   = out_dat.scalar_b;
  assign out_seq        = out_dat.seq;
  assign out_illegal    = out_dat.illegal;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Purpose : self-checking bench for instr_decode_pipe against a queue-based behavioural model.
// Latency : n/a.
// Backpr. : random and directed out_ready stalls.
module tb_instr_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_mode;
  logic [12:0] out_addr_a, out_addr_b, out_addr_out, out_addr_const;
  logic [9:0]  out_opcode;
  logic [22:0] out_len;
  logic [2:0]  out_vpu_type, out_vreg_dst, out_vreg_a, out_vreg_b, out_vpu_opcode;
  logic        out_scalar_b;
  logic [7:0]  out_seq;
  logic        out_illegal;
  logic        halted;
  logic        halt_clr;

  instr_decode_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_mode       (out_mode),
    .out_addr_a     (out_addr_a),
    .out_addr_b     (out_addr_b),
    .out_addr_out   (out_addr_out),
    .out_addr_const (out_addr_const),
    .out_opcode     (out_opcode),
    .out_len        (out_len),
    .out_vpu_type   (out_vpu_type),
    .out_vreg_dst   (out_vreg_dst),
    .out_vreg_a     (out_vreg_a),
    .out_vreg_b     (out_vreg_b),
    .out_vpu_opcode (out_vpu_opcode),
    .out_scalar_b   (out_scalar_b),
    .out_seq        (out_seq),
    .out_illegal    (out_illegal),
    .halted         (halted),
    .halt_clr       (halt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mode, addr_a, addr_b, addr_out, addr_const, opcode, len;
    logic [63:0] vpu_type, vreg_dst, vreg_a, vreg_b, vpu_opcode, scalar_b, seq, illegal;
  } exp_t;

  exp_t q[$];
  bit   m_halted;
  int   m_cnt;
  int   vectors = 0;
  int   errors  = 0;

  localparam logic [63:0] HALT = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] fld(logic [63:0] w, int lsb, int width);
    return (w >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic exp_t model_decode(logic [63:0] w, int seq);
    exp_t e;
    e.mode       = fld(w, 62, 2);
    e.addr_a     = fld(w, 49, 13);
    e.addr_b     = fld(w, 36, 13);
    e.addr_out   = fld(w, 23, 13);
    e.addr_const = fld(w, 10, 13);
    e.opcode     = fld(w, 0, 10);
    e.len        = fld(w, 0, 23);
    e.vpu_type   = fld(w, 20, 3);
    e.vreg_dst   = fld(w, 17, 3);
    e.vreg_a     = fld(w, 14, 3);
    e.vreg_b     = fld(w, 11, 3);
    e.vpu_opcode = fld(w, 4, 3);
    e.scalar_b   = fld(w, 3, 1);
    e.seq        = 64'(seq % 256);
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
    e.illegal    = (e.mode == 64'd3 && e.vpu_type >= 64'd5) ? 64'd1 : 64'd0;
`else
    e.illegal    = 64'd0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(!m_halted && q.size() < 2));
    chk("halted", 64'(halted), 64'(m_halted));
    if (q.size() > 0) begin
      chk("mode", 64'(out_mode), q[0].mode);
      chk("addr_a", 64'(out_addr_a), q[0].addr_a);
      chk("addr_b", 64'(out_addr_b), q[0].addr_b);
      chk("addr_out", 64'(out_addr_out), q[0].addr_out);
      chk("addr_const", 64'(out_addr_const), q[0].addr_const);
      chk("opcode", 64'(out_opcode), q[0].opcode);
      chk("len", 64'(out_len), q[0].len);
      chk("vpu_type", 64'(out_vpu_type), q[0].vpu_type);
      chk("vreg_dst", 64'(out_vreg_dst), q[0].vreg_dst);
      chk("vreg_a", 64'(out_vreg_a), q[0].vreg_a);
      chk("vreg_b", 64'(out_vreg_b), q[0].vreg_b);
      chk("vpu_opcode", 64'(out_vpu_opcode), q[0].vpu_opcode);
      chk("scalar_b", 64'(out_scalar_b), q[0].scalar_b);
      chk("seq", 64'(out_seq), q[0].seq);
      chk("illegal", 64'(out_illegal), q[0].illegal);
    end
  endtask

  // Called just after a falling edge: check, drive, advance the model, wait one full cycle.
  task automatic cycle(input logic v, input logic [63:0] w, input logic ordy, input logic clr);
    bit acc;
    check_outputs();
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    halt_clr  = clr;
    acc = v && !m_halted && q.size() < 2;
    if (ordy && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      if (w == HALT) m_halted = 1'b1;
      else begin
        q.push_back(model_decode(w, m_cnt));
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    if (clr) begin
      m_halted = 1'b0;
      m_cnt    = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; halt_clr = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (2) @(negedge clk);
    q.delete(); m_halted = 1'b0; m_cnt = 0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_out_seq", 64'(out_seq), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_out_len", 64'(out_len), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) w[63:62] = 2'b11;
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    @(negedge clk);
    do_reset();

    // Basic decode, literal expectations pin the model.
    cycle(1'b1, 64'h4000_0000_0000_0003, 1'b1, 1'b0);
    chk("lit_mode", 64'(out_mode), 64'd1);
    chk("lit_opcode", 64'(out_opcode), 64'h3);
    chk("lit_addr_a", 64'(out_addr_a), 64'd0);
    chk("lit_addr_const", 64'(out_addr_const), 64'd0);
    chk("lit_seq0", 64'(out_seq), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // halt_clr in RUN only zeroes the counter; then two words under backpressure.
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 64'h0004_0000_0000_0011, 1'b0, 1'b0);
    cycle(1'b1, 64'h0000_0000_0000_0C22, 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_first_seq", 64'(out_seq), 64'd0);
    chk("bp_first_addr_a", 64'(out_addr_a), 64'd2);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_second_seq", 64'(out_seq), 64'd1);
    chk("bp_second_const", 64'(out_addr_const), 64'd3);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Sequence wrap: 256 words, the 257th is tagged 0.
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) begin
      w = rand_word(); w[0] = 1'b0;
      cycle(1'b1, w, 1'b1, 1'b0);
    end
    chk("wrap_seq255", 64'(out_seq), 64'd255);
    cycle(1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b0);
    chk("wrap_seq0", 64'(out_seq), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // HALT: A forwarded, HALT consumed, B blocked until halt_clr.
    cycle(1'b1, 64'h0000_0000_0000_0155, 1'b1, 1'b0);
    cycle(1'b1, HALT, 1'b1, 1'b0);
    chk("halt_set", 64'(halted), 64'd1);
    chk("halt_not_fwd", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h0002_0000_0000_0077, 1'b1, 1'b0);
    chk("halt_blocks", 64'(in_ready), 64'd0);
    cycle(1'b1, 64'h0002_0000_0000_0077, 1'b1, 1'b1);
    chk("halt_clr_not_taken", 64'(out_valid), 64'd0);
    cycle(1'b1, 64'h0002_0000_0000_0077, 1'b1, 1'b0);
    chk("resume_seq0", 64'(out_seq), 64'd0);
    chk("resume_addr_a", 64'(out_addr_a), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Illegal VPU type check.
    cycle(1'b1, 64'hC000_0000_0060_0000, 1'b0, 1'b0);
    cycle(1'b1, 64'hC000_0000_0020_0000, 1'b0, 1'b0);
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
    chk("illegal_type6", 64'(out_illegal), 64'd1);
`else
    chk("illegal_type6", 64'(out_illegal), 64'd0);
`endif
    chk("vpu_type6", 64'(out_vpu_type), 64'd6);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("illegal_type2", 64'(out_illegal), 64'd0);
    chk("vpu_type2", 64'(out_vpu_type), 64'd2);

    // Reset mid-transfer with both entries full.
    cycle(1'b1, rand_word(), 1'b0, 1'b0);
    cycle(1'b1, rand_word(), 1'b0, 1'b0);
    do_reset();

    // Randomized traffic with occasional HALT words and clears.
    for (int i = 0; i < 3000; i++) begin
      logic v, r, c;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      w = ($urandom_range(0, 39) == 0) ? HALT : rand_word();
      if (m_halted) c = ($urandom_range(0, 4) == 0);
      else begin
        c = ($urandom_range(0, 49) == 0);
        if (c) v = 1'b0;
      end
      cycle(v, w, r, c);
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
